// File: rtl/press_timer.sv
// press_timer: turns the raw jump button into a one-shot distance pulse on
// jump_dist. The button is synchronised and debounced, the hold time is
// counted in prescaled ticks, and the final distance is driven for a short
// window followed by a forced-zero cooldown.
//
// Optional feature: define PRESS_TIMER_AUTOFIRE_EN to fire automatically when
// the charge saturates while the button is still held.
//
// Debug outputs dbg_state_o / dbg_btn_db_o expose the FSM state and the
// debounced button level.
module press_timer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 16,
  parameter int MAX_DIST        = 60,
  parameter int HOLD_CYCLES     = 2,
  parameter int COOL_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       restart_n,
  input  logic       btn,
  output logic [7:0] jump_dist,
  output logic [7:0] charge,
  output logic       charging,
  output logic       busy,
  output logic [1:0] dbg_state_o,
  output logic       dbg_btn_db_o
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW  = (TICK_DIV > 1)        ? $clog2(TICK_DIV)        : 1;
  localparam int HW  = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
  localparam int CW  = (COOL_CYCLES > 1)     ? $clog2(COOL_CYCLES)     : 1;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]  P_LAST  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0]  H_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  C_LAST  = CW'(COOL_CYCLES - 1);
  localparam logic [7:0]     MAX_D   = 8'(MAX_DIST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHARGE = 2'd1,
    S_EMIT   = 2'd2,
    S_COOL   = 2'd3
  } state_e;

  logic           sync1_q, sync2_q;
  logic           settled_q;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           btn_db_q, btn_db_d;
  logic           armed_q, armed_d;
  state_e         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [7:0]     dist_q, dist_d;
  logic [7:0]     out_val_q, out_val_d;
  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [CW-1:0]  ccnt_q, ccnt_d;

  // Two-flop synchroniser; settled_q marks that the first real sample of btn
  // has entered the pipe (right after reset the pipe only holds reset zeros,
  // so arming must wait one cycle or a button held through reset would arm).
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      settled_q <= 1'b1;
    end
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES mismatching samples in a row.
  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = ~btn_db_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Main FSM next state plus counter and flag updates.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    dist_d    = dist_q;
    out_val_d = out_val_q;
    hcnt_d    = hcnt_q;
    ccnt_d    = ccnt_q;
    armed_d   = armed_q;
    case (state_q)
      S_IDLE: begin
        // Arm only once the button is cleanly low all the way through the pipe.
        if (settled_q && !btn_db_q && !sync2_q && !sync1_q) armed_d = 1'b1;
        if (btn_db_q && armed_q) begin
          state_d = S_CHARGE;
          presc_d = '0;
          dist_d  = '0;
        end
      end
      S_CHARGE: begin
        if (!btn_db_q) begin
          // A tap shorter than one tick still produces a jump of 1.
          state_d   = S_EMIT;
          out_val_d = (dist_q == 8'd0) ? 8'd1 : dist_q;
          hcnt_d    = '0;
        end
`ifdef PRESS_TIMER_AUTOFIRE_EN
        else if (dist_q == MAX_D) begin
          state_d   = S_EMIT;
          out_val_d = MAX_D;
          hcnt_d    = '0;
          armed_d   = 1'b0;
        end
`endif
        else begin
          presc_d = presc_q + 1'b1;
          if (presc_q == P_LAST) begin
            presc_d = '0;
            if (dist_q < MAX_D) dist_d = dist_q + 8'd1;
          end
        end
      end
      S_EMIT: begin
        if (hcnt_q == H_LAST) begin
          state_d = S_COOL;
          ccnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_COOL: begin
        if (ccnt_q == C_LAST) begin
          state_d = S_IDLE;
          armed_d = 1'b0;
        end else begin
          ccnt_d = ccnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset returns everything to IDLE at once.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      db_cnt_q  <= '0;
      btn_db_q  <= 1'b0;
      armed_q   <= 1'b0;
      state_q   <= S_IDLE;
      presc_q   <= '0;
      dist_q    <= '0;
      out_val_q <= '0;
      hcnt_q    <= '0;
      ccnt_q    <= '0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      btn_db_q  <= btn_db_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      presc_q   <= presc_d;
      dist_q    <= dist_d;
      out_val_q <= out_val_d;
      hcnt_q    <= hcnt_d;
      ccnt_q    <= ccnt_d;
    end
  end

  // Outputs decode straight from registered state so reset zeroes them immediately.
  always_comb begin
    jump_dist    = (state_q == S_EMIT)   ? out_val_q : 8'd0;
    charge       = (state_q == S_CHARGE) ? dist_q    : 8'd0;
    charging     = (state_q == S_CHARGE);
    busy         = (state_q == S_EMIT) || (state_q == S_COOL);
    dbg_state_o  = state_q;
    dbg_btn_db_o = btn_db_q;
  end

endmodule

// File: tb/tb_press_timer.sv
// Directed bench for press_timer with default parameters. Inputs change 1 ns
// after a rising edge and outputs are sampled at the same point.
module tb_press_timer;

  logic       clk = 1'b0;
  logic       restart_n = 1'b0;
  logic       btn = 1'b0;
  logic [7:0] jump_dist, charge;
  logic       charging, busy;
  logic [1:0] dbg_state;
  logic       dbg_btn_db;

  int tests = 0;
  int fails = 0;

  press_timer dut (
    .clk         (clk),
    .restart_n   (restart_n),
    .btn         (btn),
    .jump_dist   (jump_dist),
    .charge      (charge),
    .charging    (charging),
    .busy        (busy),
    .dbg_state_o (dbg_state),
    .dbg_btn_db_o(dbg_btn_db)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run n cycles counting cycles with charging, non-zero jump_dist, and btn_db high.
  task automatic watch(input int n, output int n_chg, output int n_jump, output int n_db);
    n_chg = 0; n_jump = 0; n_db = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (charging) n_chg++;
      if (jump_dist != 8'd0) n_jump++;
      if (dbg_btn_db) n_db++;
    end
  endtask

  int a, b, c;

  initial begin
    // ---- Reset with the button held ----
    btn = 1'b1;
    cyc(3);
    check("rst jump_dist", jump_dist, 0);
    check("rst charge", charge, 0);
    check("rst charging", charging, 0);
    check("rst busy", busy, 0);
    check("rst state", dbg_state, 0);
    check("rst btn_db", dbg_btn_db, 0);
    restart_n = 1'b1;
    watch(40, a, b, c);
    check("held-through-reset charging", a, 0);
    check("held-through-reset jump", b, 0);
    check("held-through-reset btn_db", dbg_btn_db, 1);
    check("held-through-reset state", dbg_state, 0);
    btn = 1'b0;
    cyc(12);
    check("release btn_db", dbg_btn_db, 0);

    // ---- Normal press: about 100 CHARGE cycles -> distance 6 ----
    btn = 1'b1;
    cyc(6);
    check("press btn_db", dbg_btn_db, 1);
    check("press charging early", charging, 0);
    cyc(1);
    check("press charging", charging, 1);
    check("press charge start", charge, 0);
    cyc(93);
    btn = 1'b0;
    cyc(6);
    check("normal charge before release", charge, 6);
    check("normal jump during charge", jump_dist, 0);
    check("normal still charging", charging, 1);
    cyc(1);
    check("normal emit 1", jump_dist, 6);
    check("normal busy", busy, 1);
    check("normal charging off", charging, 0);
    cyc(1);
    check("normal emit 2", jump_dist, 6);
    cyc(1);
    check("normal cool jump", jump_dist, 0);
    check("normal cool busy", busy, 1);
    watch(7, a, b, c);
    check("normal cool zeros", b, 0);
    check("normal cool busy end", busy, 1);
    cyc(1);
    check("normal idle busy", busy, 0);
    check("normal idle state", dbg_state, 0);

    // ---- Glitch reject: 3-cycle pulse ----
    btn = 1'b1;
    watch(3, a, b, c);
    check("glitch btn_db during", c, 0);
    btn = 1'b0;
    watch(20, a, b, c);
    check("glitch btn_db", c, 0);
    check("glitch charging", a, 0);
    check("glitch jump", b, 0);

    // ---- Tap: 5-cycle raw pulse -> distance 1 ----
    btn = 1'b1;
    cyc(5);
    btn = 1'b0;
    cyc(7);
    check("tap emit 1", jump_dist, 1);
    cyc(1);
    check("tap emit 2", jump_dist, 1);
    cyc(1);
    check("tap cool jump", jump_dist, 0);
    check("tap cool busy", busy, 1);
    // Press during cooldown, held past its end: must never charge.
    btn = 1'b1;
    watch(30, a, b, c);
    check("cool press charging", a, 0);
    check("cool press jump", b, 0);
    check("cool press state", dbg_state, 0);
    btn = 1'b0;
    watch(12, a, b, c);
    check("cool press release charging", a, 0);
    check("cool press release btn_db", dbg_btn_db, 0);

`ifdef PRESS_TIMER_AUTOFIRE_EN
    // ---- Autofire: continuous hold fires 60 after 960 CHARGE cycles ----
    btn = 1'b1;
    cyc(7);
    check("auto charging", charging, 1);
    cyc(960);
    check("auto charge full", charge, 60);
    check("auto no jump yet", jump_dist, 0);
    cyc(1);
    check("auto emit 1", jump_dist, 60);
    check("auto btn still held", dbg_btn_db, 1);
    cyc(1);
    check("auto emit 2", jump_dist, 60);
    cyc(1);
    check("auto cool", jump_dist, 0);
    watch(40, a, b, c);
    check("auto no refire jump", b, 0);
    check("auto no recharge", a, 0);
    btn = 1'b0;
    cyc(12);
    btn = 1'b1;
    cyc(7);
    check("auto second press charging", charging, 1);
    btn = 1'b0;
    watch(25, a, b, c);
    check("auto second press jump cycles", b, 2);
    check("auto second press idle", busy, 0);
`else
    // ---- Saturation: 2000-cycle hold -> 60 ----
    btn = 1'b1;
    cyc(2000);
    check("sat charge", charge, 60);
    check("sat charging", charging, 1);
    check("sat no jump while held", jump_dist, 0);
    btn = 1'b0;
    cyc(6);
    check("sat pre-emit", jump_dist, 0);
    cyc(1);
    check("sat emit 1", jump_dist, 60);
    cyc(1);
    check("sat emit 2", jump_dist, 60);
    cyc(1);
    check("sat cool", jump_dist, 0);
    cyc(10);
    check("sat idle", busy, 0);
`endif

    // ---- Reset in the middle of EMIT ----
    btn = 1'b1;
    cyc(40);
    btn = 1'b0;
    cyc(7);
    check("midrst emit", jump_dist, 2);
    #2;
    restart_n = 1'b0;
    #1;
    check("midrst jump immediate", jump_dist, 0);
    check("midrst busy immediate", busy, 0);
    check("midrst state immediate", dbg_state, 0);
    cyc(2);
    restart_n = 1'b1;
    watch(20, a, b, c);
    check("midrst no jump after", b, 0);
    check("midrst no charge after", a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/press_timer.md
# press_timer

Button-to-jump-distance transmitter for the game FSM. Synchronises and debounces the raw jump button, measures hold time in prescaled ticks, and drives the 8-bit `jump_dist` bus. The bus follows the FSM's end-of-jump protocol: zero while idle or charging, then the final distance for a short window, then zero again. The FSM's two-deep sample shift register sees a non-zero value followed by a zero and triggers exactly one jump.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical synchronised samples required to change the debounced level.
- `TICK_DIV`, default 16: CHARGE cycles per distance unit.
- `MAX_DIST`, default 60: saturation value of the distance; range 1..255.
- `HOLD_CYCLES`, default 2: cycles the final distance is driven; must be ≥1.
- `COOL_CYCLES`, default 8: forced-zero cycles after EMIT; must be ≥1.
- `clk  in  1`: game clock. All state updates on posedge, so `jump_dist` is stable at the FSM's negedge sample.
- `restart_n  in  1`: asynchronous active-low reset.
- `btn  in  1`: raw, asynchronous, active-high jump button.
- `jump_dist  out  8`: distance bus to the FSM.
- `charge  out  8`: live charge level, for the power-bar display.
- `charging  out  1`: high in CHARGE.
- `busy  out  1`: high in EMIT or COOLDOWN.

## Operation
- **Synchroniser:** 2-flop synchroniser on `btn`, giving `btn_s`.
- **Debounce:** a counter compares `btn_s` with `btn_db`.
  - On mismatch, the counter increments.
  - When it reaches `DEBOUNCE_CYCLES-1` on a mismatching cycle, `btn_db` toggles and the counter clears.
  - Any matching cycle clears the counter.
- **`armed` flag:** set in IDLE when `btn_db`=0. A press is accepted only when `armed`=1. A button still held when COOLDOWN ends therefore never starts a new charge.
- **IDLE:** `jump_dist`=0 and `charge`=0.
  - `btn_db`=1 and `armed`=1 → CHARGE, with `presc`=0 and `dist`=0.
- **CHARGE:**
  - Each cycle `presc` increments.
  - When `presc`==`TICK_DIV-1`, `presc` clears and `dist` = min(`dist`+1, `MAX_DIST`).
  - `charge`=`dist`. `jump_dist` stays 0.
  - `btn_db`=0 → EMIT, with `out_val`=max(`dist`,1) and `hcnt`=0. The `dist` update in the release cycle is not applied.
- **EMIT:**
  - `jump_dist`=`out_val` for exactly `HOLD_CYCLES` cycles.
  - Then → COOLDOWN with `ccnt`=0.
- **COOLDOWN:**
  - `jump_dist`=0 for `COOL_CYCLES` cycles.
  - Then → IDLE with `armed`=0.
- **Width rules:** `dist` is 8-bit and saturating, never wrapping. `presc`, `hcnt`, `ccnt` and the debounce counter are sized with $clog2 of their parameter, minimum 1 bit.
- **Encoding:** two-bit state, IDLE=0, CHARGE=1, EMIT=2, COOLDOWN=3.
- **Illegal state:** → IDLE on the next edge.
- **Button activity in EMIT/COOLDOWN:** ignored.

## Timing
- **Reset values:** every output is 0. Internally:
  - state=IDLE;
  - `btn_db`=0 and both synchroniser flops are 0;
  - `armed`=0;
  - all counters are 0.
- **Reset in mid-operation:** returns to IDLE immediately and asynchronously. `jump_dist` drops to 0 in the same instant, and no partial distance is ever emitted.
- **Press latency:** `btn` rise → `btn_db`=1 takes 2 cycles of synchroniser plus `DEBOUNCE_CYCLES`. `charging` rises one cycle after `btn_db` rises.
- **Release latency:** `btn_db` fall → `jump_dist`≠0 on the next posedge.
- **Protocol guarantee:** each accepted press yields exactly one contiguous non-zero run of length `HOLD_CYCLES`, followed by ≥`COOL_CYCLES` zeros.
- **Distance formula:** after `btn_db` is high for N CHARGE cycles, `dist` = min(floor(N/`TICK_DIV`), `MAX_DIST`).

## Configuration
- **`PRESS_TIMER_AUTOFIRE_EN` defined:** if CHARGE reaches `dist`==`MAX_DIST` while still held, the block behaves as if released.
  - It moves to EMIT with `out_val`=`MAX_DIST`.
  - `armed` clears, so the ongoing hold cannot re-trigger.
- **Undefined:** CHARGE saturates and waits indefinitely for release.

## Test plan
- **Reset:**
  - Stimulus: assert `restart_n`=0 with `btn`=1.
  - Required: all outputs 0.
  - After deassert with `btn` still high, no charge starts until `btn` goes low and is pressed again.
- **Normal press (defaults):**
  - Stimulus: debounced hold of 100 CHARGE cycles, then release.
  - Required: `jump_dist`=6 for exactly 2 cycles, then 0 for ≥8 cycles.
  - Required: `charge` reads 6 just before release.
- **Glitch reject:**
  - Stimulus: 3-cycle `btn` pulse.
  - Required: `btn_db` never rises, `charging` stays 0, `jump_dist` stays 0.
- **Tap and saturation:**
  - Stimulus: 5-cycle hold.
  - Required: `jump_dist`=1.
  - Stimulus: 2000-cycle hold with autofire off.
  - Required: `jump_dist`=60 on release.
- **Autofire:**
  - Stimulus: `PRESS_TIMER_AUTOFIRE_EN` defined, continuous hold.
  - Required: `jump_dist`=60 emitted after 960 CHARGE cycles, while `btn` is still 1.
  - Required: no second emission until the button is released and pressed again.
- **Reset mid-EMIT and busy presses:**
  - Stimulus: `restart_n` pulse during EMIT.
  - Required: `jump_dist` is 0 immediately.
  - Stimulus: a press during COOLDOWN.
  - Required: ignored, with no CHARGE entry.
